data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory slave with fixed wait states
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-low
//   req_valid  in   request present
//   req_ready  out  high only when idle
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address (must be word aligned and below DEPTH_WORDS*4)
//   req_wdata  in   store data
//   req_wstrb  in   byte-lane enables for stores
//   rsp_valid  out  response present, held until rsp_ready
//   rsp_ready  in   initiator accepts response
//   rsp_rdata  out  load data (0 for stores, faults, and when rsp_valid=0)
//   rsp_err    out  access fault (0 when rsp_valid=0)
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U   = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // The access happens on the edge entering RESP. With zero wait states that
  // edge is the accept edge itself, so the request is taken straight from the
  // inputs; otherwise it comes from the latched copy.
  logic        enter_resp;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wstrb;
  logic        acc_fault;
  logic [AW-1:0] acc_idx;
  logic        mem_we;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    enter_resp = 1'b0;
    acc_write  = write_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    acc_wstrb  = wstrb_q;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        acc_write = req_write;
        acc_addr  = req_addr;
        acc_wdata = req_wdata;
        acc_wstrb = req_wstrb;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    acc_fault = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH_U);
    acc_idx   = acc_addr[AW+1:2];

    if (enter_resp) begin
      err_d   = acc_fault;
      rdata_d = (acc_fault || acc_write) ? 32'd0 : mem[acc_idx];
    end

    // Qualified by reset so nothing is committed while reset is held.
    mem_we = enter_resp && acc_write && !acc_fault && reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - bench for data_mem_responder (2 and 0 wait-state builds)
module tb_data_mem_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk;
  logic        reset;
  logic        req_valid_s [2];
  logic        req_ready_s [2];
  logic        req_write_s [2];
  logic [31:0] req_addr_s  [2];
  logic [31:0] req_wdata_s [2];
  logic [3:0]  req_wstrb_s [2];
  logic        rsp_valid_s [2];
  logic        rsp_ready_s [2];
  logic [31:0] rsp_rdata_s [2];
  logic        rsp_err_s   [2];

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W0)) u0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_write(req_write_s[0]),
    .req_addr(req_addr_s[0]), .req_wdata(req_wdata_s[0]), .req_wstrb(req_wstrb_s[0]),
    .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]),
    .rsp_rdata(rsp_rdata_s[0]), .rsp_err(rsp_err_s[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_write(req_write_s[1]),
    .req_addr(req_addr_s[1]), .req_wdata(req_wdata_s[1]), .req_wstrb(req_wstrb_s[1]),
    .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]),
    .rsp_rdata(rsp_rdata_s[1]), .rsp_err(rsp_err_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  function automatic int wc(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  // Transaction-level model: one outstanding request per instance; the
  // response is due WAIT_CYCLES edges after accept and lasts until handshake.
  logic [31:0] mdl_mem [2][256];
  bit          pend    [2];
  int          acc_at  [2];
  logic        m_wr    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_strb  [2];
  logic [31:0] exp_rd  [2];
  logic        exp_er  [2];
  int          n = 0;

  task automatic model_access(input int d);
    if (m_addr[d][1:0] != 2'b00 || m_addr[d][31:2] >= 30'd256) begin
      exp_er[d] = 1'b1;
      exp_rd[d] = 32'd0;
    end else if (m_wr[d]) begin
      for (int b = 0; b < 4; b++)
        if (m_strb[d][b]) mdl_mem[d][m_addr[d][9:2]][8*b +: 8] = m_wdata[d][8*b +: 8];
      exp_er[d] = 1'b0;
      exp_rd[d] = 32'd0;
    end else begin
      exp_er[d] = 1'b0;
      exp_rd[d] = mdl_mem[d][m_addr[d][9:2]];
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) pend[d] = 1'b0;
    forever begin
      @(posedge clk);
      n++;
      for (int d = 0; d < 2; d++) begin
        if (!reset) begin
          pend[d] = 1'b0;
        end else begin
          if (pend[d] && (n - 1) >= acc_at[d] + wc(d)) begin
            if (rsp_ready_s[d]) pend[d] = 1'b0;
          end else if (!pend[d] && req_valid_s[d]) begin
            pend[d]    = 1'b1;
            acc_at[d]  = n;
            m_wr[d]    = req_write_s[d];
            m_addr[d]  = req_addr_s[d];
            m_wdata[d] = req_wdata_s[d];
            m_strb[d]  = req_wstrb_s[d];
          end
          if (pend[d] && n == acc_at[d] + wc(d)) model_access(d);
        end
      end
      #2;
      for (int d = 0; d < 2; d++) begin
        logic ev;
        ev = pend[d] && (n >= acc_at[d] + wc(d));
        chk($sformatf("u%0d rsp_valid @%0d", d, n), 32'(rsp_valid_s[d]), 32'(ev));
        chk($sformatf("u%0d req_ready @%0d", d, n), 32'(req_ready_s[d]), 32'(!pend[d]));
        chk($sformatf("u%0d rsp_rdata @%0d", d, n), rsp_rdata_s[d], ev ? exp_rd[d] : 32'd0);
        chk($sformatf("u%0d rsp_err @%0d", d, n), 32'(rsp_err_s[d]), ev ? 32'(exp_er[d]) : 32'd0);
      end
    end
  end

  // Issues one request from an idle DUT, scrambles the inputs after accept,
  // optionally holds rsp_ready low for `hold` cycles, then completes it.
  task automatic do_req(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat);
    int k;
    logic [31:0] r0;
    logic e0;
    req_write_s[d] = wr;
    req_addr_s[d]  = addr;
    req_wdata_s[d] = wdata;
    req_wstrb_s[d] = strb;
    req_valid_s[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_s[d] = 1'b0;
    req_write_s[d] = ~wr;
    req_addr_s[d]  = 32'hFFFF_FFFC;
    req_wdata_s[d] = ~wdata;
    req_wstrb_s[d] = 4'hF;
    k = 0;
    while (!rsp_valid_s[d] && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL u%0d rsp_timeout: got no rsp_valid, required one within 40 cycles", d);
    end
    lat = k + 1;
    r0 = rsp_rdata_s[d];
    e0 = rsp_err_s[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("u%0d hold valid %0d", d, i), 32'(rsp_valid_s[d]), 32'd1);
      chk($sformatf("u%0d hold rdata %0d", d, i), rsp_rdata_s[d], r0);
      chk($sformatf("u%0d hold err %0d", d, i), 32'(rsp_err_s[d]), 32'(e0));
      chk($sformatf("u%0d hold req_ready %0d", d, i), 32'(req_ready_s[d]), 32'd0);
    end
    rdata = rsp_rdata_s[d];
    err   = rsp_err_s[d];
    rsp_ready_s[d] = 1'b1;
    @(negedge clk);
    rsp_ready_s[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required one within 100000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid_s[d] = 1'b0;
      req_write_s[d] = 1'b0;
      req_addr_s[d]  = 32'd0;
      req_wdata_s[d] = 32'd0;
      req_wstrb_s[d] = 4'd0;
      rsp_ready_s[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready_s[0]), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid_s[0]), 32'd0);
    reset = 1'b1;

    // Store then load, two wait states.
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    chk("store lat", 32'(lat), 32'd3);
    chk("store err", 32'(er), 32'd0);
    chk("store rdata", rd, 32'd0);
    do_req(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er, lat);
    chk("load lat", 32'(lat), 32'd3);
    chk("load rdata", rd, 32'hDEADBEEF);
    chk("load err", 32'(er), 32'd0);

    // Byte lanes.
    do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat);
    do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
    do_req(0, 1'b0, 32'h20, 32'd0, 4'h0, 0, rd, er, lat);
    chk("lane rdata", rd, 32'h11BB33DD);

    // Faults.
    do_req(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    do_req(0, 1'b0, 32'h13, 32'd0, 4'h0, 0, rd, er, lat);
    chk("misalign err", 32'(er), 32'd1);
    chk("misalign rdata", rd, 32'd0);
    do_req(0, 1'b1, 32'h400, 32'h55555555, 4'hF, 0, rd, er, lat);
    chk("range err", 32'(er), 32'd1);
    do_req(0, 1'b0, 32'h0, 32'd0, 4'h0, 0, rd, er, lat);
    chk("word0 intact", rd, 32'hCAFEF00D);

    // Last word, and an empty strobe.
    do_req(0, 1'b1, 32'h3FC, 32'h0F0F1234, 4'hF, 0, rd, er, lat);
    do_req(0, 1'b0, 32'h3FC, 32'd0, 4'h0, 0, rd, er, lat);
    chk("last word", rd, 32'h0F0F1234);
    do_req(0, 1'b1, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("nostrb err", 32'(er), 32'd0);

    // Backpressure.
    do_req(0, 1'b0, 32'h10, 32'd0, 4'h0, 5, rd, er, lat);
    chk("bp rdata", rd, 32'hDEADBEEF);

    // Reset in the middle of a store's wait states.
    do_req(0, 1'b1, 32'h30, 32'h0BADC0DE, 4'hF, 0, rd, er, lat);
    req_write_s[0] = 1'b1;
    req_addr_s[0]  = 32'h30;
    req_wdata_s[0] = 32'h12345678;
    req_wstrb_s[0] = 4'hF;
    req_valid_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_s[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid reset req_ready", 32'(req_ready_s[0]), 32'd1);
    chk("mid reset rsp_valid", 32'(rsp_valid_s[0]), 32'd0);
    chk("mid reset rsp_rdata", rsp_rdata_s[0], 32'd0);
    chk("mid reset rsp_err", 32'(rsp_err_s[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_req(0, 1'b0, 32'h30, 32'd0, 4'h0, 0, rd, er, lat);
    chk("post reset lat", 32'(lat), 32'd3);
    chk("post reset rdata", rd, 32'h0BADC0DE);

    // Zero wait states, back to back.
    do_req(1, 1'b1, 32'h8, 32'h5A5A5A5A, 4'hF, 0, rd, er, lat);
    chk("w0 store lat", 32'(lat), 32'd1);
    do_req(1, 1'b1, 32'hC, 32'hA5A5A5A5, 4'hF, 0, rd, er, lat);
    do_req(1, 1'b0, 32'h8, 32'd0, 4'h0, 0, rd, er, lat);
    chk("w0 load8", rd, 32'h5A5A5A5A);
    chk("w0 load lat", 32'(lat), 32'd1);
    do_req(1, 1'b0, 32'hC, 32'd0, 4'h0, 0, rd, er, lat);
    chk("w0 loadC", rd, 32'hA5A5A5A5);
    do_req(1, 1'b0, 32'h2, 32'd0, 4'h0, 0, rd, er, lat);
    chk("w0 misalign err", 32'(er), 32'd1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
